fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the RISC-V pipeline. It owns the program counter and drives the word-addressed instruction memory's combinational read port. It registers each returned instruction with its PC into the IF/ID pipeline register, sustaining one fetch per cycle. It also handles decode back-pressure, branch redirects from execute, halt detection and optional static backward-branch prediction.

## Interface
Parameters:
- WIDTH1, 32: PC and instruction width.
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- HALT_INSTR, 32'h0000_5063: encoding of `BGE x0,x0,0`, treated as the halt instruction.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  WIDTH1  byte address to instruction memory; always equals the internal pc.
- imem_rdata  in  WIDTH1  instruction word, valid combinationally in the same cycle as imem_addr.
- imem_wr  out  1  tied 0; the fetch stage never writes.
- redirect_valid  in  1  execute resolved a taken branch, jump or mispredict.
- redirect_pc  in  WIDTH1  target for the redirect.
- id_ready  in  1  decode can accept the IF/ID register this cycle.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_instr  out  WIDTH1  registered instruction.
- id_pc  out  WIDTH1  registered PC of id_instr.
- id_pred_taken  out  1  fetch predicted id_instr taken.
- halted  out  1  state is HALT.

## Operation
- State machine states:
  - RUN: normal fetching.
  - HALT: fetching stopped.
- Advance condition: `adv = !id_valid || id_ready`.
- Priority each cycle, highest first:
  1. reset.
  2. redirect_valid.
  3. Stall: `!adv`.
  4. Fetch.
- Redirect, in any state:
  - pc <= {redirect_pc[31:2], 2'b00}; the low bits are forced to zero.
  - id_valid <= 0; any in-flight instruction is squashed.
  - id_pred_taken <= 0.
  - state <= RUN.
- Stall: pc, id_* and state all hold.
- Fetch in RUN with adv:
  - id_instr <= imem_rdata, id_pc <= pc, id_valid <= 1.
  - pc <= next_pc.
  - If imem_rdata == HALT_INSTR: still forward it to decode, set state <= HALT and hold pc.
- HALT with adv: id_valid <= 0; pc holds. HALT is left only by redirect or reset.
- Default next_pc = pc + 4, modulo 2^32 (wraps from 0xFFFF_FFFC to 0).
- PC arithmetic is unsigned WIDTH1 bits; branch immediates are sign-extended from 13 bits.

## Timing
- Reset values: pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pred_taken=0, halted=0, state=RUN.
- imem_addr reflects pc with zero latency; fetch-to-id latency is 1 cycle.
- First id_valid=1 at the first rising edge after reset deasserts, carrying id_pc=RESET_PC.
- Throughput: 1 instruction per cycle while id_ready=1.
- Redirect penalty: redirect in cycle N gives id_valid=0 after edge N. The target instruction appears after edge N+1.
- Redirect coinciding with a stall: the redirect wins and the held instruction is dropped.
- Redirect coinciding with halt detection: the redirect wins and the state stays RUN.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

## Configuration
- FETCH_STATIC_PREDICT_EN defined:
  - When imem_rdata[6:0]==7'b1100011 (B-type) and imm[12]=1 (backward), next_pc = pc + sext({imem_rdata[31], imem_rdata[7], imem_rdata[30:25], imem_rdata[11:8], 1'b0}).
  - id_pred_taken <= 1 for that fetch.
  - Forward branches predict not-taken.
  - Execute is responsible for redirecting on mispredict.
- Not defined: next_pc is always pc+4 (unless halted or redirected), and id_pred_taken is tied 0.

## Test plan
- Reset and stream: release reset with RESET_PC=0, id_ready=1 and sequential ADDIs in memory -> id_pc takes 0,4,8,12 on consecutive edges, id_valid=1 from the first edge.
- Stall: hold id_ready=0 for 3 cycles while id_pc=0x8 -> id_pc/id_instr frozen at 0x8 and imem_addr stays 0xC. Release -> next id_pc=0xC.
- Redirect: assert redirect_valid with redirect_pc=0x33 while id_valid=1 -> next cycle id_valid=0 and imem_addr=0x30. Following cycle id_pc=0x30.
- Halt: place 0x0000_5063 at 0x40 -> id_instr=0x0000_5063 with id_pc=0x40, then halted=1 and id_valid=0 with imem_addr frozen. Redirect to 0x0 -> fetching resumes.
- Prediction with FETCH_STATIC_PREDICT_EN defined: fetch BLT x13,x12,-8 (0xFEC6_CCE3) at 0x38 -> id_pred_taken=1 and next id_pc=0x30.
- Prediction without FETCH_STATIC_PREDICT_EN: same instruction -> next id_pc=0x3C and id_pred_taken=0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch stage bus: instruction memory read port, execute redirect and IF/ID register outputs.
interface fetch_if #(
    parameter int WIDTH1 = 32
);
    logic [WIDTH1-1:0] imem_addr;
    logic [WIDTH1-1:0] imem_rdata;
    logic              imem_wr;
    logic              redirect_valid;
    logic [WIDTH1-1:0] redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [WIDTH1-1:0] id_instr;
    logic [WIDTH1-1:0] id_pc;
    logic              id_pred_taken;
    logic              halted;

    modport master (
        output imem_addr, imem_wr, id_valid, id_instr, id_pc, id_pred_taken, halted,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_addr, imem_wr, id_valid, id_instr, id_pc, id_pred_taken, halted,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, fills the IF/ID register, handles stall, redirect and halt.
// Define FETCH_STATIC_PREDICT_EN to predict backward B-type branches taken.
module fetch_stage #(
    parameter int                WIDTH1     = 32,
    parameter logic [WIDTH1-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [WIDTH1-1:0] HALT_INSTR = 32'h0000_5063
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t            state;
    logic [WIDTH1-1:0] pc;
    logic [WIDTH1-1:0] next_pc;
    logic [WIDTH1-1:0] id_instr;
    logic [WIDTH1-1:0] id_pc;
    logic              id_valid;
    logic              id_pred_taken;
    logic              adv;
    logic              is_halt;
    logic              pred_bwd;

    assign adv     = !id_valid || bus.id_ready;
    assign is_halt = (bus.imem_rdata == HALT_INSTR);

`ifdef FETCH_STATIC_PREDICT_EN
    logic [WIDTH1-1:0] br_off;

    // B-type immediate; bit 31 is imm[12], so a set sign bit means a backward branch.
    assign br_off   = {{(WIDTH1-12){bus.imem_rdata[31]}}, bus.imem_rdata[7],
                       bus.imem_rdata[30:25], bus.imem_rdata[11:8], 1'b0};
    assign pred_bwd = (bus.imem_rdata[6:0] == 7'b1100011) && bus.imem_rdata[31];
    assign next_pc  = pred_bwd ? pc + br_off : pc + WIDTH1'(4);
`else
    assign pred_bwd = 1'b0;
    assign next_pc  = pc + WIDTH1'(4);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            pc            <= RESET_PC;
            id_valid      <= 1'b0;
            id_instr      <= '0;
            id_pc         <= '0;
            id_pred_taken <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect squashes whatever sits in IF/ID, even if decode is stalled.
            state         <= RUN;
            pc            <= {bus.redirect_pc[WIDTH1-1:2], 2'b00};
            id_valid      <= 1'b0;
            id_pred_taken <= 1'b0;
        end else if (adv) begin
            case (state)
                RUN: begin
                    id_instr      <= bus.imem_rdata;
                    id_pc         <= pc;
                    id_valid      <= 1'b1;
                    id_pred_taken <= pred_bwd;
                    if (is_halt) state <= HALT;
                    else         pc    <= next_pc;
                end
                HALT: id_valid <= 1'b0;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.imem_addr     = pc;
    assign bus.imem_wr       = 1'b0;
    assign bus.id_valid      = id_valid;
    assign bus.id_instr      = id_instr;
    assign bus.id_pc         = id_pc;
    assign bus.id_pred_taken = id_pred_taken;
    assign bus.halted        = (state == HALT);
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboard of expected IF/ID deliveries plus per-scenario inline checks.
module tb_fetch_stage;
    localparam logic [31:0] HALT_W = 32'h0000_5063;
    localparam logic [31:0] BLT_W  = 32'hFEC6_CCE3;
`ifdef FETCH_STATIC_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] mem [0:255];
    exp_t        sb [$];
    exp_t        mon_e;
    int          checks;
    int          errors;

    fetch_if #(.WIDTH1(32)) bus ();

    fetch_stage #(.WIDTH1(32), .RESET_PC(32'h0), .HALT_INSTR(HALT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_rdata = mem[bus.imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    function automatic void push(input logic [31:0] a, input logic p);
        exp_t e;
        e.pc = a; e.instr = word(a); e.pred = p;
        sb.push_back(e);
    endfunction

    // Decode accepts IF/ID when valid and ready at the coming edge; compare against queue head.
    always @(negedge clk) begin
        if (!reset && bus.id_valid && bus.id_ready && sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (bus.id_pc !== mon_e.pc || bus.id_instr !== mon_e.instr || bus.id_pred_taken !== mon_e.pred) begin
                errors++;
                $display("FAIL sb_deliver got pc=%h instr=%h pred=%b exp pc=%h instr=%h pred=%b",
                         bus.id_pc, bus.id_instr, bus.id_pred_taken, mon_e.pc, mon_e.instr, mon_e.pred);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.id_ready = 1'b1;
        sb.delete();
        #2;
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.id_valid); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus.imem_addr); end
        checks++; if ({bus.id_pc, bus.id_instr} !== 64'h0) begin errors++; $display("FAIL rst_idregs got %h %h exp 0 0", bus.id_pc, bus.id_instr); end
        checks++; if ({bus.halted, bus.id_pred_taken, bus.imem_wr} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {bus.halted, bus.id_pred_taken, bus.imem_wr}); end
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0 || bus.id_pc !== 32'h0) begin
            errors++; $display("FAIL rst_async got valid=%b addr=%h pc=%h exp 0 0 0", bus.id_valid, bus.imem_addr, bus.id_pc);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stream_pre got valid=%b addr=%h exp 0 0", bus.id_valid, bus.imem_addr); end
        for (int i = 0; i < 4; i++) push(32'(4*i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4*i)) begin
                errors++; $display("FAIL stream_pc got valid=%b pc=%h exp 1 %h", bus.id_valid, bus.id_pc, 32'(4*i));
            end
        end
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain got %0d exp 0", sb.size()); end
    endtask

    task automatic test_stall();
        do_reset();
        push(32'h0, 1'b0); push(32'h4, 1'b0); push(32'h8, 1'b0); push(32'hC, 1'b0);
        tick(); tick(); tick();
        bus.id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus.id_pc !== 32'h8 || bus.id_instr !== word(32'h8) || bus.imem_addr !== 32'hC || bus.id_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold got pc=%h instr=%h addr=%h exp 8 %h c", bus.id_pc, bus.id_instr, bus.imem_addr, word(32'h8));
            end
        end
        bus.id_ready = 1'b1;
        tick();
        checks++; if (bus.id_pc !== 32'hC) begin errors++; $display("FAIL stall_release got %h exp c", bus.id_pc); end
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL stall_drain got %0d exp 0", sb.size()); end
    endtask

    task automatic test_redirect();
        do_reset();
        push(32'h0, 1'b0); push(32'h30, 1'b0);
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h33;
        tick();
        checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h30) begin
            errors++; $display("FAIL redir_squash got valid=%b addr=%h exp 0 30", bus.id_valid, bus.imem_addr);
        end
        bus.redirect_valid = 1'b0;
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h30) begin errors++; $display("FAIL redir_target got valid=%b pc=%h exp 1 30", bus.id_valid, bus.id_pc); end
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL redir_drain got %0d exp 0", sb.size()); end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        push(32'h20, 1'b0);
        tick();
        bus.id_ready = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h20;
        tick();
        checks++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h20) begin
            errors++; $display("FAIL redir_stall got valid=%b addr=%h exp 0 20", bus.id_valid, bus.imem_addr);
        end
        bus.redirect_valid = 1'b0; bus.id_ready = 1'b1;
        tick();
        checks++; if (bus.id_pc !== 32'h20) begin errors++; $display("FAIL redir_stall_pc got %h exp 20", bus.id_pc); end
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL redir_stall_drain got %0d exp 0", sb.size()); end
    endtask

    task automatic test_halt();
        do_reset();
        push(32'h0, 1'b0); push(32'h3C, 1'b0); push(32'h40, 1'b0);
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3C;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.id_pc !== 32'h40 || bus.id_instr !== HALT_W || bus.halted !== 1'b1) begin
            errors++; $display("FAIL halt_detect got pc=%h instr=%h halted=%b exp 40 %h 1", bus.id_pc, bus.id_instr, bus.halted, HALT_W);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (bus.id_valid !== 1'b0 || bus.halted !== 1'b1 || bus.imem_addr !== 32'h40) begin
                errors++; $display("FAIL halt_hold got valid=%b halted=%b addr=%h exp 0 1 40", bus.id_valid, bus.halted, bus.imem_addr);
            end
        end
        push(32'h0, 1'b0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
        tick();
        checks++; if (bus.halted !== 1'b0 || bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL halt_exit got halted=%b valid=%b addr=%h exp 0 0 0", bus.halted, bus.id_valid, bus.imem_addr);
        end
        bus.redirect_valid = 1'b0;
        tick();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin errors++; $display("FAIL halt_resume got valid=%b pc=%h exp 1 0", bus.id_valid, bus.id_pc); end
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_drain got %0d exp 0", sb.size()); end
    endtask

    task automatic test_halt_redirect();
        do_reset();
        push(32'h0, 1'b0); push(32'h10, 1'b0);
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        tick();
        bus.redirect_pc = 32'h10;
        tick();
        checks++; if (bus.halted !== 1'b0 || bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h10) begin
            errors++; $display("FAIL halt_redir got halted=%b valid=%b addr=%h exp 0 0 10", bus.halted, bus.id_valid, bus.imem_addr);
        end
        bus.redirect_valid = 1'b0;
        tick();
        checks++; if (bus.id_pc !== 32'h10 || bus.halted !== 1'b0) begin errors++; $display("FAIL halt_redir_pc got pc=%h halted=%b exp 10 0", bus.id_pc, bus.halted); end
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL halt_redir_drain got %0d exp 0", sb.size()); end
    endtask

    task automatic test_predict();
        logic [31:0] nxt;
        nxt = PRED ? 32'h30 : 32'h3C;
        do_reset();
        push(32'h0, 1'b0); push(32'h38, PRED); push(nxt, 1'b0);
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h38;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        checks++; if (bus.id_pc !== 32'h38 || bus.id_instr !== BLT_W || bus.id_pred_taken !== PRED) begin
            errors++; $display("FAIL pred_flag got pc=%h instr=%h pred=%b exp 38 %h %b", bus.id_pc, bus.id_instr, bus.id_pred_taken, BLT_W, PRED);
        end
        tick();
        checks++; if (bus.id_pc !== nxt || bus.id_pred_taken !== 1'b0) begin
            errors++; $display("FAIL pred_next got pc=%h pred=%b exp %h 0", bus.id_pc, bus.id_pred_taken, nxt);
        end
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL pred_drain got %0d exp 0", sb.size()); end
    endtask

    task automatic test_wrap();
        do_reset();
        push(32'h0, 1'b0); push(32'hFFFF_FFFC, 1'b0); push(32'h0, 1'b0);
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF;
        tick();
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h exp fffffffc", bus.imem_addr); end
        bus.redirect_valid = 1'b0;
        tick();
        checks++; if (bus.id_pc !== 32'hFFFF_FFFC || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_pc got pc=%h addr=%h exp fffffffc 0", bus.id_pc, bus.imem_addr);
        end
        tick();
        checks++; if (bus.id_pc !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", bus.id_pc); end
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", sb.size()); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = {12'(i), 5'd0, 3'd0, 5'd1, 7'h13};
        mem[14] = BLT_W;
        mem[16] = HALT_W;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_halt_redirect();
        test_predict();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
